// File: rtl/bytestream_packet_decoder.sv
// Unescapes the host byte stream into sop/eop/channel packet beats behind a single output register.
// Optional BYTESTREAM_DECODER_STATS_EN adds pkt_count and err_count outputs.
//
// state  | meaning
// IDLE   | no packet open; a data byte without a pending SOP is a protocol error
// IN_PKT | a SOP beat was delivered and no EOP beat has followed yet
module bytestream_packet_decoder #(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter logic [7:0]  ESC_XOR       = 8'h20
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  input  logic                     out_ready,
  output logic                     proto_error
`ifdef BYTESTREAM_DECODER_STATS_EN
  ,
  output logic [15:0]              pkt_count,
  output logic [15:0]              err_count
`endif
);

  localparam logic [7:0] K_SOP  = 8'h7A;
  localparam logic [7:0] K_EOP  = 8'h7B;
  localparam logic [7:0] K_CHAN = 8'h7C;
  localparam logic [7:0] K_ESC  = 8'h7D;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                   state, state_n;
  logic                     sop_pend, eop_pend, chan_pend, esc_pend;
  logic                     sop_n, eop_n, chan_n, esc_n;
  logic [CHANNEL_WIDTH-1:0] channel, channel_n;
  logic                     accept, load, err, is_ctrl;
  logic [7:0]               byte_val;

  // Held low through reset so nothing upstream is consumed before the decoder is live.
  assign in_ready = reset_n & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign is_ctrl  = (in_data == K_SOP) || (in_data == K_EOP) || (in_data == K_CHAN);

  always_comb begin
    state_n   = state;
    sop_n     = sop_pend;
    eop_n     = eop_pend;
    chan_n    = chan_pend;
    esc_n     = esc_pend;
    channel_n = channel;
    byte_val  = in_data;
    load      = 1'b0;
    err       = 1'b0;
    if (accept) begin
      if (esc_pend) begin
        esc_n    = 1'b0;
        byte_val = in_data ^ ESC_XOR;
        if (chan_pend) begin
          chan_n    = 1'b0;
          channel_n = byte_val[CHANNEL_WIDTH-1:0];
        end else begin
          load = 1'b1;
        end
      end else if (in_data == K_ESC) begin
        esc_n = 1'b1;
      end else if (chan_pend && !is_ctrl) begin
        chan_n    = 1'b0;
        channel_n = in_data[CHANNEL_WIDTH-1:0];
      end else begin
        // A control byte where a channel number was expected aborts the channel load.
        if (chan_pend) begin
          chan_n = 1'b0;
          err    = 1'b1;
        end
        case (in_data)
          K_SOP: begin
            if (eop_pend || state == IN_PKT) err = 1'b1;
            eop_n = 1'b0;
            sop_n = 1'b1;
          end
          K_EOP: begin
            if (eop_pend) err = 1'b1;
            eop_n = 1'b1;
          end
          K_CHAN:  chan_n = 1'b1;
          default: load   = 1'b1;
        endcase
      end
    end
    if (load) begin
      if (!sop_pend && state == IDLE) err = 1'b1;
      sop_n = 1'b0;
      eop_n = 1'b0;
      if (eop_pend)      state_n = IDLE;
      else if (sop_pend) state_n = IN_PKT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sop_pend  <= 1'b0;
      eop_pend  <= 1'b0;
      chan_pend <= 1'b0;
      esc_pend  <= 1'b0;
      channel   <= '0;
    end else begin
      state     <= state_n;
      sop_pend  <= sop_n;
      eop_pend  <= eop_n;
      chan_pend <= chan_n;
      esc_pend  <= esc_n;
      channel   <= channel_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_channel <= '0;
      proto_error <= 1'b0;
    end else begin
      proto_error <= err;
      if (load) begin
        out_valid   <= 1'b1;
        out_data    <= byte_val;
        out_sop     <= sop_pend;
        out_eop     <= eop_pend;
        out_channel <= channel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BYTESTREAM_DECODER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (out_valid && out_ready && out_eop) pkt_count <= pkt_count + 16'd1;
      if (proto_error && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bytestream_packet_decoder.sv
// Bench for bytestream_packet_decoder: vector table, hand sequences and a random stream
// scored against a whole-stream decoding model.
module tb_bytestream_packet_decoder;
  localparam int CW = 8;
  localparam logic [7:0] CMASK = 8'((1 << CW) - 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_sop;
  logic          out_eop;
  logic [CW-1:0] out_channel;
  logic          out_ready = 1'b1;
  logic          proto_error;
`ifdef BYTESTREAM_DECODER_STATS_EN
  logic [15:0]   pkt_count;
  logic [15:0]   err_count;
`endif

  bytestream_packet_decoder #(.CHANNEL_WIDTH(CW), .ESC_XOR(8'h20)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_channel(out_channel),
    .out_ready(out_ready), .proto_error(proto_error)
`ifdef BYTESTREAM_DECODER_STATS_EN
    , .pkt_count(pkt_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [17:0] got[$];
  int err_seen = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) got.push_back({out_sop, out_eop, 8'(out_channel), out_data});
      if (proto_error) err_seen++;
    end
  end

  typedef struct {
    logic [63:0] s;
    int          n;
    logic [71:0] b;
    int          nb;
    int          errs;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [17:0] bt(input bit sop, input bit eop, input logic [7:0] ch, input logic [7:0] d);
    return {sop, eop, ch, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-stream reference: escapes resolved first, then control bytes and data beats.
  function automatic void model(input logic [7:0] s[$], output logic [17:0] q[$], output int errs);
    bit sp = 0, ep = 0, cp = 0, es = 0, inpkt = 0, lit, e;
    logic [7:0] ch = 8'h00, v;
    q.delete();
    errs = 0;
    foreach (s[i]) begin
      v = s[i]; lit = 0; e = 0;
      if (es) begin v = v ^ 8'h20; lit = 1; es = 0; end
      else if (v == 8'h7D) begin es = 1; continue; end
      if (cp) begin
        cp = 0;
        if (lit || !(v inside {8'h7A, 8'h7B, 8'h7C})) begin ch = v & CMASK; continue; end
        e = 1;
      end
      if (!lit && v == 8'h7A) begin
        if (ep || inpkt) e = 1;
        ep = 0; sp = 1;
      end else if (!lit && v == 8'h7B) begin
        if (ep) e = 1;
        ep = 1;
      end else if (!lit && v == 8'h7C) begin
        cp = 1;
      end else begin
        if (!sp && !inpkt) e = 1;
        q.push_back({sp, ep, ch, v});
        if (ep) inpkt = 0; else if (sp) inpkt = 1;
        sp = 0; ep = 0;
      end
      if (e) errs++;
    end
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_proto_error", 32'(proto_error), 0);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    got.delete();
    err_seen = 0;
  endtask

  task automatic drive(input logic [7:0] s[$], input int vpct, input int rpct);
    int idx = 0;
    int cyc = 0;
    while (idx < s.size() && cyc < 5000) begin
      in_valid  = ($urandom_range(99) < vpct);
      in_data   = s[idx];
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (idx < s.size()) begin
      checks++; errors++;
      $display("FAIL drive_timeout: consumed %0d of %0d bytes", idx, s.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input logic [17:0] exp[$], input int exp_errs);
    chk($sformatf("%s beats", name), 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s beat%0d", name, i), 32'(got[i]), 32'(exp[i]));
    chk($sformatf("%s proto_error", name), 32'(err_seen), 32'(exp_errs));
  endtask

  task automatic set_vec(input int k, input logic [63:0] s, input int n, input logic [71:0] b, input int nb, input int e);
    tbl[k].s = s; tbl[k].n = n; tbl[k].b = b; tbl[k].nb = nb; tbl[k].errs = e;
  endtask

  logic [7:0]  sq[$];
  logic [17:0] eq[$];
  int          ne, neop, r;

  initial begin
    set_vec(0, 64'h7A7C0311227B3300, 7, {bt(1,0,8'h03,8'h11), bt(0,0,8'h03,8'h22), bt(0,1,8'h03,8'h33), 18'h0}, 3, 0);
    set_vec(1, 64'h7A7D5A7B7D5D0000, 6, {bt(1,0,8'h00,8'h7A), bt(0,1,8'h00,8'h7D), 36'h0}, 2, 0);
    set_vec(2, 64'h7A017A027B030000, 6, {bt(1,0,8'h00,8'h01), bt(1,0,8'h00,8'h02), bt(0,1,8'h00,8'h03), 18'h0}, 3, 1);
    set_vec(3, 64'h7C7B440000000000, 3, {bt(0,1,8'h00,8'h44), 54'h0}, 1, 2);
    set_vec(4, 64'h7A7D7D7B7D5C0000, 6, {bt(1,0,8'h00,8'h5D), bt(0,1,8'h00,8'h7C), 36'h0}, 2, 0);
    set_vec(5, 64'h7A7D7C7B01000000, 5, {bt(1,0,8'h00,8'h5C), bt(0,1,8'h00,8'h01), 36'h0}, 2, 0);
    set_vec(6, 64'h7A117B7A227B3300, 7, {bt(1,0,8'h00,8'h11), bt(1,0,8'h00,8'h22), bt(0,1,8'h00,8'h33), 18'h0}, 3, 1);
    set_vec(7, 64'h7A7B7B4400000000, 4, {bt(1,1,8'h00,8'h44), 54'h0}, 1, 1);
    set_vec(8, 64'h7C7D5A7A667B7700, 7, {bt(1,0,8'h7A,8'h66), bt(0,1,8'h7A,8'h77), 36'h0}, 2, 0);
    set_vec(9, 64'h7C7C057A097B0A00, 7, {bt(1,0,8'h05,8'h09), bt(0,1,8'h05,8'h0A), 36'h0}, 2, 1);

    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 10; k++) begin
        do_reset();
        sq.delete(); eq.delete();
        for (int i = 0; i < tbl[k].n; i++) sq.push_back(tbl[k].s[63-8*i -: 8]);
        for (int i = 0; i < tbl[k].nb; i++) eq.push_back(tbl[k].b[71-18*i -: 18]);
        drive(sq, pass ? 60 : 100, pass ? 50 : 100);
        compare($sformatf("vec%0d_p%0d", k, pass), eq, tbl[k].errs);
      end
    end

    // Backpressure: first beat appears one cycle after acceptance and holds while stalled.
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h7A;
    @(posedge clk); #1;
    in_data = 8'h01;
    chk("bp_no_early_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    in_data = 8'h02;
    chk("bp_latency_valid", 32'(out_valid), 1);
    chk("bp_first_beat", 32'({out_sop, out_eop, out_data}), 32'({2'b10, 8'h01}));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 1);
      chk($sformatf("bp_hold_data%0d", i), 32'(out_data), 32'h01);
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_beat", 32'({out_valid, out_sop, out_data}), 32'({2'b10, 8'h02}));
    @(posedge clk); #1;
    chk("bp_drained", 32'(out_valid), 0);

    // Reset mid-packet drops the registered beat and all pending state.
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h7A;
    @(posedge clk); #1;
    in_data = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_beat_held", 32'(out_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'({out_valid, out_sop, out_eop, out_data, 8'(out_channel)}), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    got.delete(); err_seen = 0;
    sq.delete(); sq.push_back(8'h7B); sq.push_back(8'h55);
    drive(sq, 100, 100);
    eq.delete(); eq.push_back(bt(0, 1, 8'h00, 8'h55));
    compare("mid_rst", eq, 1);
`ifdef BYTESTREAM_DECODER_STATS_EN
    chk("mid_rst_pkt_count", 32'(pkt_count), 1);
    chk("mid_rst_err_count", 32'(err_count), 1);
`endif

    // Random streams biased toward control bytes.
    for (int run = 0; run < 3; run++) begin
      do_reset();
      sq.delete();
      for (int i = 0; i < 400; i++) begin
        r = $urandom_range(9);
        if (r < 4) sq.push_back(8'(8'h7A + r));
        else sq.push_back(8'($urandom_range(255)));
      end
      model(sq, eq, ne);
      case (run)
        0:       drive(sq, 100, 100);
        1:       drive(sq, 70, 50);
        default: drive(sq, 40, 90);
      endcase
      compare($sformatf("rand%0d", run), eq, ne);
      neop = 0;
      foreach (eq[i]) if (eq[i][16]) neop++;
`ifdef BYTESTREAM_DECODER_STATS_EN
      chk($sformatf("rand%0d_pkt_count", run), 32'(pkt_count), 32'(neop));
      chk($sformatf("rand%0d_err_count", run), 32'(err_count), 32'(ne));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
